// File: rtl/id_framer_pkg.sv
// id_framer_pkg: shared state encoding, code type and letter-to-code table for the ID framer
package id_framer_pkg;
  typedef enum logic [1:0] {COLLECT, SEND, WAIT} state_t;
  typedef logic [5:0] code_t;
  localparam int ID_LEN_DEF = 10;
  localparam code_t LETTER_CODE [26] = '{
    6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd34, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd35, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd32, 6'd30, 6'd31, 6'd33
  };
endpackage

// File: rtl/id_char_decode.sv
// id_char_decode: classifies an ASCII char as letter/digit and maps it to its checker code; ID_FRAMER_LOWER_EN folds lowercase onto uppercase
module id_char_decode
  import id_framer_pkg::*;
(
  input  logic [7:0] char_data,
  output logic       is_letter,
  output logic       is_digit,
  output code_t      code
);
  logic [7:0] up;
  logic [4:0] idx;
  // fold case when enabled, then look the letter up or take the digit value
  always_comb begin
`ifdef ID_FRAMER_LOWER_EN
    up = (char_data >= "a" && char_data <= "z") ? char_data - 8'd32 : char_data;
`else
    up = char_data;
`endif
    is_digit = char_data >= "0" && char_data <= "9";
    is_letter = up >= "A" && up <= "Z";
    idx = 5'(up - 8'd65);
    code = is_digit ? code_t'(char_data - 8'd48) : is_letter ? LETTER_CODE[idx] : '0;
  end
endmodule

// File: rtl/id_framer.sv
// id_framer: assembles letter+digits IDs from a char stream, replays them as a gap-free burst and waits for the checker; ID_FRAMER_LOWER_EN accepts lowercase letters
module id_framer
  import id_framer_pkg::*;
#(
  parameter int ID_LEN   = ID_LEN_DEF,
  parameter int WAIT_MAX = 15,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  input  logic             chk_out_valid,
  output logic             in_valid,
  output code_t            in_id,
  output logic             fmt_err,
  output logic             to_err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int PW = $clog2(ID_LEN);
  localparam int CW = $clog2((ID_LEN > WAIT_MAX ? ID_LEN : WAIT_MAX) + 1);
  state_t state, state_nxt;
  logic [PW-1:0] pos, pos_nxt, wr_pos;
  logic [CW-1:0] cnt, cnt_nxt;
  logic iv_nxt, fmt_nxt, to_nxt, wr, is_letter, is_digit;
  code_t id_nxt, code;
  code_t buf_q [ID_LEN];
  logic [ERR_W-1:0] err_nxt;
  id_char_decode u_dec (.char_data(char_data), .is_letter(is_letter), .is_digit(is_digit), .code(code));
  assign char_ready = state == COLLECT;
  // next state, buffer write and registered-output values; a letter always restarts the frame
  always_comb begin
    state_nxt = state;
    pos_nxt = pos;
    cnt_nxt = cnt;
    iv_nxt = 1'b0;
    id_nxt = '0;
    fmt_nxt = 1'b0;
    to_nxt = 1'b0;
    wr = 1'b0;
    wr_pos = pos;
    case (state)
      COLLECT: if (char_valid) begin
        if (is_letter) begin
          wr = 1'b1;
          wr_pos = '0;
          pos_nxt = PW'(1);
          fmt_nxt = pos != '0;
        end else if (is_digit && pos != '0) begin
          wr = 1'b1;
          pos_nxt = pos == PW'(ID_LEN - 1) ? '0 : pos + 1'b1;
          if (pos == PW'(ID_LEN - 1)) begin
            state_nxt = SEND;
            cnt_nxt = CW'(1);
            iv_nxt = 1'b1;
            id_nxt = buf_q[0];
          end
        end else begin
          fmt_nxt = 1'b1;
          pos_nxt = '0;
        end
      end
      SEND: if (cnt == CW'(ID_LEN)) begin
        state_nxt = WAIT;
        cnt_nxt = '0;
      end else begin
        iv_nxt = 1'b1;
        id_nxt = buf_q[cnt];
        cnt_nxt = cnt + 1'b1;
      end
      WAIT: if (chk_out_valid || cnt == CW'(WAIT_MAX - 1)) begin
        state_nxt = COLLECT;
        cnt_nxt = '0;
        to_nxt = !chk_out_valid;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = COLLECT;
    endcase
    err_nxt = ((fmt_nxt || to_nxt) && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= COLLECT;
      pos <= '0;
      cnt <= '0;
      in_valid <= 1'b0;
      in_id <= '0;
      fmt_err <= 1'b0;
      to_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      pos <= pos_nxt;
      cnt <= cnt_nxt;
      in_valid <= iv_nxt;
      in_id <= id_nxt;
      fmt_err <= fmt_nxt;
      to_err <= to_nxt;
      err_cnt <= err_nxt;
    end
  // character buffer, written only while collecting
  always_ff @(posedge clk)
    if (wr) buf_q[wr_pos] <= code;
endmodule

// File: tb/tb_id_framer.sv
// tb_id_framer: randomized and directed stimulus against a queue-based reference model of the ID framer
module tb_id_framer;
  localparam int ID_LEN = 10;
  localparam int WAIT_MAX = 15;
  localparam int ERR_W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic char_valid = 1'b0;
  logic [7:0] char_data = '0;
  logic chk_out_valid = 1'b0;
  logic char_ready, in_valid, fmt_err, to_err;
  logic [5:0] in_id;
  logic [ERR_W-1:0] err_cnt;
  int checks = 0;
  int errors = 0;
  int col[$];
  int burst[$];
  int wait_left = 0;
  int e_err = 0;
  bit e_fmt = 0;
  bit e_to = 0;
  int ov_mode = 1;
  bit gaps = 0;
  string order = "ABCDEFGHJKLMNPQRSTUVXYWZIO";
  always #5 clk = ~clk;
  id_framer dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .chk_out_valid(chk_out_valid), .in_valid(in_valid),
    .in_id(in_id), .fmt_err(fmt_err), .to_err(to_err), .err_cnt(err_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic int decode(input byte c);
    byte u = c;
`ifdef ID_FRAMER_LOWER_EN
    if (c >= "a" && c <= "z") u = byte'(c - 32);
`endif
    if (c >= "0" && c <= "9") return c - "0";
    for (int i = 0; i < 26; i++) if (order[i] == u) return i + 10;
    return -1;
  endfunction
  function automatic bit m_ready();
    return burst.size() == 0 && wait_left == 0;
  endfunction
  task automatic m_reset();
    col.delete();
    burst.delete();
    wait_left = 0;
    e_err = 0;
    e_fmt = 0;
    e_to = 0;
  endtask
  task automatic step(input bit cv, input byte cd);
    bit ov;
    int c;
    ov = 1'b0;
    if (ov_mode == 1) ov = wait_left == WAIT_MAX;
    if (ov_mode == 2) ov = (wait_left == WAIT_MAX) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
    char_valid = cv;
    char_data = cd;
    chk_out_valid = ov;
    #1;
    chk("char_ready", char_ready, m_ready());
    chk("in_valid", in_valid, burst.size() != 0);
    chk("in_id", in_id, burst.size() != 0 ? burst[0] : 0);
    chk("fmt_err", fmt_err, e_fmt);
    chk("to_err", to_err, e_to);
    chk("err_cnt", err_cnt, e_err);
    e_fmt = 0;
    e_to = 0;
    if (burst.size() != 0) begin
      void'(burst.pop_front());
      if (burst.size() == 0) wait_left = WAIT_MAX;
    end else if (wait_left != 0) begin
      if (ov) wait_left = 0;
      else begin
        wait_left--;
        e_to = wait_left == 0;
      end
    end else if (cv && rst_n) begin
      c = decode(cd);
      if (c >= 10) begin
        e_fmt = col.size() != 0;
        col.delete();
        col.push_back(c);
      end else if (c >= 0 && col.size() != 0) begin
        col.push_back(c);
        if (col.size() == ID_LEN) begin
          burst = col;
          col.delete();
        end
      end else begin
        e_fmt = 1;
        col.delete();
      end
    end
    if ((e_fmt || e_to) && e_err < (1 << ERR_W) - 1) e_err++;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, byte'($urandom));
  endtask
  task automatic send_ch(input byte c);
    int n = 0;
    if (gaps) idle($urandom_range(0, 2));
    while (!m_ready() && n < 100) begin
      step(1'b0, byte'($urandom));
      n++;
    end
    if (n == 100) chk("ready_timeout", char_ready, 1);
    step(1'b1, c);
  endtask
  task automatic send_str(input string s);
    foreach (s[i]) send_ch(s[i]);
  endtask
  initial begin
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_str("A123456789");
    idle(30);
    send_str("I000000000O111111111W222222222");
    idle(30);
    send_str("A12X456789012");
    idle(30);
    send_str("A12#B987654321");
    idle(30);
    ov_mode = 0;
    send_str("Z555555555");
    idle(30);
    ov_mode = 1;
    send_str("C314159265");
    idle(4);
    chk("pre_rst_iv", in_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_valid", in_valid, 0);
    chk("rst_in_id", in_id, 0);
    chk("rst_err_cnt", err_cnt, 0);
    m_reset();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(15);
    send_str("a123456789");
    idle(30);
    gaps = 1;
    ov_mode = 2;
    for (int t = 0; t < 40; t++) begin
      byte s[ID_LEN];
      s[0] = byte'($urandom_range(0, 1) ? $urandom_range(65, 90) : $urandom_range(97, 122));
      for (int i = 1; i < ID_LEN; i++) s[i] = byte'($urandom_range(48, 57));
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, ID_LEN - 1)] = byte'($urandom);
      foreach (s[i]) send_ch(s[i]);
    end
    idle(30);
    gaps = 0;
    ov_mode = 1;
    repeat (260) send_ch("#");
    idle(3);
    chk("err_sat", err_cnt, 255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
